// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: LED_W-wide pattern driver with four step rates and
// four pattern modes (rotate, bounce, fill, dark-rotate). Run/pause and
// single-step come from raw push buttons through a 2-flop synchroniser and a
// level debouncer.
// Optional build macro PWM_DIM_EN adds a 4-bit brightness input and a
// 16-slot PWM dimmer on the LED output. The output and tick are then
// registered one cycle behind the pattern.
module led_pattern_sequencer #(
  parameter int unsigned LED_W     = 8,
  parameter int unsigned CNT_W     = 26,
  parameter int unsigned DIV0      = 99_999,
  parameter int unsigned DIV1      = 999_999,
  parameter int unsigned DIV2      = 4_999_999,
  parameter int unsigned DIV3      = 19_999_999,
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned DB_W      = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic [1:0]       freq_set,
  input  logic [1:0]       mode,
  input  logic             dir_set,
`ifdef PWM_DIM_EN
  input  logic [3:0]       bright,
`endif
  output logic [LED_W-1:0] led,
  output logic             running,
  output logic             tick
);

  typedef enum logic [1:0] {
    M_ROTATE = 2'b00,
    M_BOUNCE = 2'b01,
    M_FILL   = 2'b10,
    M_DARK   = 2'b11
  } mode_e;

  localparam logic [LED_W-1:0] LED_ONE = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);

  // Index 0 is the run/pause button, index 1 is the single-step button.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      db_q, db_d;
  logic [1:0]      pulse_q;
  logic [DB_W-1:0] dbc_q [2];
  logic [DB_W-1:0] dbc_d [2];

  logic             running_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_max;
  logic             cnt_end;
  logic             step;

  mode_e            mode_q;
  mode_e            mode_in;
  logic             mode_chg;
  logic [LED_W-1:0] led_q, pat_d;
  logic             bounce_up_q, up_d;
  logic             tick_q;

  assign btn_raw = {btn_step, btn_run};

  // Seed loaded whenever the selected mode changes.
  function automatic logic [LED_W-1:0] seed(input mode_e m);
    case (m)
      M_FILL:  seed = '0;
      M_DARK:  seed = ~LED_ONE;
      default: seed = LED_ONE;
    endcase
  endfunction

  // Debounce next state: count while the synced level disagrees with the
  // accepted level, accept it once it has held for DB_CYCLES cycles.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i];
      dbc_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

  // Button synchronisers, debounce state and rising-edge pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      pulse_q <= '0;
      for (int i = 0; i < 2; i++) dbc_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      pulse_q <= db_d & ~db_q;
      for (int i = 0; i < 2; i++) dbc_q[i] <= dbc_d[i];
    end
  end

  // Rate select follows the live switches, so a lowered limit takes effect
  // on the very next cycle.
  always_comb begin
    case (freq_set)
      2'b00:   cnt_max = CNT_W'(DIV0);
      2'b01:   cnt_max = CNT_W'(DIV1);
      2'b10:   cnt_max = CNT_W'(DIV2);
      default: cnt_max = CNT_W'(DIV3);
    endcase
  end

  assign cnt_end  = (cnt_q >= cnt_max);
  assign step     = (running_q & cnt_end) | (~running_q & pulse_q[1]);
  assign mode_in  = mode_e'(mode);
  assign mode_chg = (mode_in != mode_q);

  // Run flag toggle and prescaler; the count is frozen (not cleared) on pause.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      running_q <= running_q ^ pulse_q[0];
      if (running_q) begin
        cnt_q <= cnt_end ? '0 : cnt_q + 1'b1;
      end
    end
  end

  // Next pattern for one step in the current mode.
  always_comb begin
    pat_d = led_q;
    up_d  = bounce_up_q;
    case (mode_q)
      M_BOUNCE: begin
        if (bounce_up_q) begin
          if (led_q[LED_W-1]) begin
            up_d  = 1'b0;
            pat_d = led_q >> 1;
          end else begin
            pat_d = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            up_d  = 1'b1;
            pat_d = led_q << 1;
          end else begin
            pat_d = led_q >> 1;
          end
        end
      end
      M_FILL: begin
        if (&led_q) begin
          pat_d = '0;
        end else if (dir_set) begin
          pat_d = {1'b1, led_q[LED_W-1:1]};
        end else begin
          pat_d = {led_q[LED_W-2:0], 1'b1};
        end
      end
      default: begin
        if (dir_set) begin
          pat_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        end else begin
          pat_d = {led_q[0], led_q[LED_W-1:1]};
        end
      end
    endcase
  end

  // Pattern register: a mode change reloads the seed and wins over a step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q      <= M_ROTATE;
      led_q       <= LED_ONE;
      bounce_up_q <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      mode_q <= mode_in;
      tick_q <= 1'b0;
      if (mode_chg) begin
        led_q       <= seed(mode_in);
        bounce_up_q <= 1'b1;
      end else if (step) begin
        led_q       <= pat_d;
        bounce_up_q <= up_d;
        tick_q      <= 1'b1;
      end
    end
  end

`ifdef PWM_DIM_EN
  logic [3:0]       pwm_cnt_q;
  logic [LED_W-1:0] led_out_q;
  logic             tick_out_q;

  // PWM dimmer: output stage one cycle behind the pattern, tick follows it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q  <= '0;
      led_out_q  <= LED_ONE;
      tick_out_q <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
      led_out_q  <= led_q & {LED_W{pwm_cnt_q <= bright}};
      tick_out_q <= tick_q;
    end
  end

  assign led  = led_out_q;
  assign tick = tick_out_q;
`else
  assign led  = led_q;
  assign tick = tick_q;
`endif

  assign running = running_q;

endmodule
